// File: rtl/mtl_avalon_cfg_master.sv
// Avalon-MM configuration master for the MTL display controller register slave.
// Executes one write / read / poll-until-match command at a time and returns one response.
// Optional poll timeout: define MTL_CFG_POLL_TIMEOUT_EN to give up after MAX_POLLS failed reads.
module mtl_avalon_cfg_master #(
   parameter int READ_LATENCY = 1,
   parameter int POLL_GAP     = 16,
   parameter int MAX_POLLS    = 1024
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        iCMD_VALID,
   output logic        oCMD_READY,
   input  logic [1:0]  iCMD_OP,
   input  logic [7:0]  iCMD_ADDR,
   input  logic [31:0] iCMD_DATA,
   input  logic [31:0] iCMD_MASK,
   output logic        oRSP_VALID,
   output logic [31:0] oRSP_DATA,
   output logic        oRSP_ERR,
   output logic        oBUSY,
   output logic [7:0]  oAvalon_address,
   output logic        oAvalon_read,
   output logic        oAvalon_write,
   output logic [31:0] oAvalon_writedata,
   input  logic [31:0] iAvalon_readdata,
   input  logic        iAvalon_waitrequest
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD, S_RD_WAIT, S_GAP, S_RSP
   } state_t;

   localparam logic [1:0] OP_WR   = 2'b00;
   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_POLL = 2'b10;

   // Elaboration-time guard on the legal parameter ranges.
   if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_read_latency
      $error("READ_LATENCY must be 1..7");
   end
   if (POLL_GAP < 1 || POLL_GAP > 65535) begin : g_bad_poll_gap
      $error("POLL_GAP must be 1..65535");
   end
   if (MAX_POLLS < 1) begin : g_bad_max_polls
      $error("MAX_POLLS must be at least 1");
   end

   state_t      state_q, state_d;
   logic [1:0]  op_q;
   logic [7:0]  addr_q;
   logic [31:0] data_q, mask_q;
   logic [2:0]  lat_q, lat_d;
   logic [15:0] gap_q, gap_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic        accept;
   logic        match;

`ifdef MTL_CFG_POLL_TIMEOUT_EN
   localparam int ATT_W = $clog2(MAX_POLLS + 1);
   logic [ATT_W-1:0] att_q, att_d;
`endif

   assign accept = iCMD_VALID && (state_q == S_IDLE);
   assign match  = ((iAvalon_readdata ^ data_q) & mask_q) == 32'd0;

   // Command fields are captured once at acceptance and stay stable for the whole command.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         op_q   <= 2'b00;
         addr_q <= 8'd0;
         data_q <= 32'd0;
         mask_q <= 32'd0;
      end else if (accept) begin
         op_q   <= iCMD_OP;
         addr_q <= iCMD_ADDR;
         data_q <= iCMD_DATA;
         mask_q <= iCMD_MASK;
      end
   end

   // State, counters and the held response registers.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q    <= S_IDLE;
         lat_q      <= 3'd0;
         gap_q      <= 16'd0;
         rsp_data_q <= 32'd0;
         rsp_err_q  <= 1'b0;
`ifdef MTL_CFG_POLL_TIMEOUT_EN
         att_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         gap_q      <= gap_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
`ifdef MTL_CFG_POLL_TIMEOUT_EN
         att_q      <= att_d;
`endif
      end
   end

   // Next-state logic; response registers only change on entry to S_RSP.
   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      gap_d      = gap_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
`ifdef MTL_CFG_POLL_TIMEOUT_EN
      att_d      = att_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               gap_d = 16'd0;
`ifdef MTL_CFG_POLL_TIMEOUT_EN
               att_d = '0;
`endif
               case (iCMD_OP)
                  OP_WR:         state_d = S_WR;
                  OP_RD, OP_POLL: state_d = S_RD;
                  default: begin
                     state_d    = S_RSP;
                     rsp_data_d = 32'd0;
                     rsp_err_d  = 1'b1;
                  end
               endcase
            end
         end
         S_WR: begin
            if (!iAvalon_waitrequest) begin
               state_d    = S_RSP;
               rsp_data_d = 32'd0;
               rsp_err_d  = 1'b0;
            end
         end
         S_RD: begin
            if (!iAvalon_waitrequest) begin
               state_d = S_RD_WAIT;
               lat_d   = 3'(READ_LATENCY);
            end
         end
         S_RD_WAIT: begin
            // Readdata is valid on the READ_LATENCY-th edge after the read was accepted.
            if (lat_q == 3'd1) begin
               if (op_q == OP_POLL && !match) begin
`ifdef MTL_CFG_POLL_TIMEOUT_EN
                  if (att_q == ATT_W'(MAX_POLLS - 1)) begin
                     state_d    = S_RSP;
                     rsp_data_d = iAvalon_readdata;
                     rsp_err_d  = 1'b1;
                  end else begin
                     att_d   = att_q + ATT_W'(1);
                     state_d = S_GAP;
                     gap_d   = 16'(POLL_GAP);
                  end
`else
                  state_d = S_GAP;
                  gap_d   = 16'(POLL_GAP);
`endif
               end else begin
                  state_d    = S_RSP;
                  rsp_data_d = iAvalon_readdata;
                  rsp_err_d  = 1'b0;
               end
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         S_GAP: begin
            if (gap_q == 16'd1) state_d = S_RD;
            else                gap_d   = gap_q - 16'd1;
         end
         S_RSP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign oCMD_READY        = (state_q == S_IDLE);
   assign oBUSY             = (state_q != S_IDLE);
   assign oRSP_VALID        = (state_q == S_RSP);
   assign oRSP_DATA         = rsp_data_q;
   assign oRSP_ERR          = rsp_err_q;
   assign oAvalon_write     = (state_q == S_WR);
   assign oAvalon_read      = (state_q == S_RD);
   assign oAvalon_address   = addr_q;
   assign oAvalon_writedata = data_q;

endmodule

// File: tb/tb_mtl_avalon_cfg_master.sv
// Directed bench for mtl_avalon_cfg_master: write, stalled write, read, poll, timeout, reserved op, reset.
// Inputs change on the falling edge; a posedge monitor counts strobes and responses.
// Slave model answers accepted reads with fixed latency 1.
module tb_mtl_avalon_cfg_master;
   localparam int READ_LATENCY = 1;
   localparam int POLL_GAP     = 16;
`ifdef MTL_CFG_POLL_TIMEOUT_EN
   localparam int MAX_POLLS    = 4;
`else
   localparam int MAX_POLLS    = 1024;
`endif
   // Edges between successive poll read accepts: RD + READ_LATENCY wait cycles + POLL_GAP idle.
   localparam int RD_SPACING   = 1 + READ_LATENCY + POLL_GAP;

   logic        iCLK = 1'b0;
   logic        iRST_n = 1'b0;
   logic        iCMD_VALID = 1'b0;
   logic [1:0]  iCMD_OP = 2'b00;
   logic [7:0]  iCMD_ADDR = 8'd0;
   logic [31:0] iCMD_DATA = 32'd0;
   logic [31:0] iCMD_MASK = 32'd0;
   logic        iAvalon_waitrequest = 1'b0;
   logic [31:0] iAvalon_readdata = 32'd0;
   logic        oCMD_READY, oRSP_VALID, oRSP_ERR, oBUSY, oAvalon_read, oAvalon_write;
   logic [31:0] oRSP_DATA, oAvalon_writedata;
   logic [7:0]  oAvalon_address;

   mtl_avalon_cfg_master #(
      .READ_LATENCY(READ_LATENCY), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)
   ) dut (
      .iCLK(iCLK), .iRST_n(iRST_n),
      .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY), .iCMD_OP(iCMD_OP),
      .iCMD_ADDR(iCMD_ADDR), .iCMD_DATA(iCMD_DATA), .iCMD_MASK(iCMD_MASK),
      .oRSP_VALID(oRSP_VALID), .oRSP_DATA(oRSP_DATA), .oRSP_ERR(oRSP_ERR), .oBUSY(oBUSY),
      .oAvalon_address(oAvalon_address), .oAvalon_read(oAvalon_read),
      .oAvalon_write(oAvalon_write), .oAvalon_writedata(oAvalon_writedata),
      .iAvalon_readdata(iAvalon_readdata), .iAvalon_waitrequest(iAvalon_waitrequest)
   );

   always #5 iCLK = ~iCLK;

   int tests_run = 0;
   int tests_failed = 0;

   // Monitor state (written only by the monitor process).
   int cyc = 0, rd_cnt = 0, rd_cyc = 0, wr_cyc = 0, both_cyc = 0, rsp_cnt = 0;
   int bad_gap = 0, bad_wr = 0, acc_cyc = 0, rsp_lat = 0, last_rd = 0;
   // Slave / expectation controls (written only by the stimulus process).
   int          rd_base = 0, zero_reads = 0;
   logic [31:0] slave_val = 32'd0;
   logic [7:0]  exp_addr = 8'd0;
   logic [31:0] exp_wdata = 32'd0;

   // Monitor plus latency-1 slave: readdata is updated on the read-accept edge.
   always @(posedge iCLK) begin
      cyc <= cyc + 1;
      if (oAvalon_read) rd_cyc <= rd_cyc + 1;
      if (oAvalon_write) begin
         wr_cyc <= wr_cyc + 1;
         if (oAvalon_address != exp_addr || oAvalon_writedata != exp_wdata) bad_wr <= bad_wr + 1;
      end
      if (oAvalon_read && oAvalon_write) both_cyc <= both_cyc + 1;
      if (oAvalon_read && !iAvalon_waitrequest) begin
         rd_cnt <= rd_cnt + 1;
         if (rd_cnt != rd_base && (cyc - last_rd) != RD_SPACING) bad_gap <= bad_gap + 1;
         last_rd <= cyc;
         iAvalon_readdata <= ((rd_cnt - rd_base) < zero_reads) ? 32'd0 : slave_val;
      end
      if (iCMD_VALID && oCMD_READY) acc_cyc <= cyc;
      if (oRSP_VALID) begin
         rsp_cnt <= rsp_cnt + 1;
         rsp_lat <= cyc - acc_cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] m);
      @(negedge iCLK);
      iCMD_VALID = 1'b1; iCMD_OP = op; iCMD_ADDR = a; iCMD_DATA = d; iCMD_MASK = m;
      @(posedge iCLK);
      @(negedge iCLK);
      iCMD_VALID = 1'b0;
   endtask

   // Waits (bounded) for one more response than base; the count itself is checked.
   task automatic wait_rsp(input string tag, input int base, input int max_cyc);
      int n = 0;
      while (rsp_cnt == base && n < max_cyc) begin
         @(negedge iCLK);
         n++;
      end
      @(negedge iCLK);
      chk(tag, rsp_cnt - base, 1);
   endtask

   initial begin
      int b_rsp, b_wr, b_rd, b_rdc, b_gap, b_bad, n;

      // Reset state
      #3;
      chk("rst_ready", 32'(oCMD_READY), 1);
      chk("rst_busy", 32'(oBUSY), 0);
      chk("rst_rd_wr", {30'd0, oAvalon_read, oAvalon_write}, 0);
      chk("rst_rsp_valid", 32'(oRSP_VALID), 0);
      repeat (2) @(negedge iCLK);
      iRST_n = 1'b1;
      repeat (2) @(negedge iCLK);

      // Read, latency 1
      slave_val = 32'h0000_005A; zero_reads = 0; rd_base = rd_cnt;
      b_rsp = rsp_cnt; b_rdc = rd_cyc;
      send(2'b01, 8'h01, 32'd0, 32'd0);
      wait_rsp("rd_rsp_count", b_rsp, 20);
      chk("rd_data", oRSP_DATA, 32'h0000_005A);
      chk("rd_err", 32'(oRSP_ERR), 0);
      chk("rd_latency", rsp_lat, 3);
      chk("rd_strobe_cycles", rd_cyc - b_rdc, 1);

      // Zero-wait write
      exp_addr = 8'h02; exp_wdata = 32'h0000_0190;
      b_rsp = rsp_cnt; b_wr = wr_cyc; b_bad = bad_wr;
      send(2'b00, 8'h02, 32'h0000_0190, 32'd0);
      wait_rsp("wr_rsp_count", b_rsp, 20);
      chk("wr_latency", rsp_lat, 2);
      chk("wr_data", oRSP_DATA, 0);
      chk("wr_err", 32'(oRSP_ERR), 0);
      chk("wr_strobe_cycles", wr_cyc - b_wr, 1);
      chk("wr_addr_data", bad_wr - b_bad, 0);

      // Write stalled 3 cycles by waitrequest
      b_rsp = rsp_cnt; b_wr = wr_cyc; b_bad = bad_wr;
      iAvalon_waitrequest = 1'b1;
      send(2'b00, 8'h02, 32'h0000_0190, 32'd0);
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      iAvalon_waitrequest = 1'b0;
      wait_rsp("wrst_rsp_count", b_rsp, 20);
      chk("wrst_strobe_cycles", wr_cyc - b_wr, 4);
      chk("wrst_addr_data_stable", bad_wr - b_bad, 0);
      chk("wrst_latency", rsp_lat, 5);
      repeat (4) @(negedge iCLK);
      chk("wrst_single_rsp", rsp_cnt - b_rsp, 1);

      // Poll: three misses then a match; a write offered meanwhile is ignored
      slave_val = 32'h0000_0001; zero_reads = 3; rd_base = rd_cnt;
      b_rsp = rsp_cnt; b_rd = rd_cnt; b_gap = bad_gap; b_wr = wr_cyc;
      send(2'b10, 8'h0A, 32'h0000_0001, 32'h0000_0001);
      iCMD_VALID = 1'b1; iCMD_OP = 2'b00;
      repeat (5) @(negedge iCLK);
      chk("poll_busy", 32'(oBUSY), 1);
      chk("poll_not_ready", 32'(oCMD_READY), 0);
      iCMD_VALID = 1'b0;
      wait_rsp("poll_rsp_count", b_rsp, 200);
      chk("poll_reads", rd_cnt - b_rd, 4);
      chk("poll_spacing", bad_gap - b_gap, 0);
      chk("poll_data", oRSP_DATA, 32'h0000_0001);
      chk("poll_err", 32'(oRSP_ERR), 0);
      chk("poll_latency", rsp_lat, 1 + 3 * RD_SPACING + 2);
      chk("poll_busy_cmd_ignored", wr_cyc - b_wr, 0);

      // Reserved opcode: error response, no bus activity
      b_rsp = rsp_cnt; b_wr = wr_cyc; b_rdc = rd_cyc;
      send(2'b11, 8'h05, 32'h1234_5678, 32'hFFFF_FFFF);
      wait_rsp("rsv_rsp_count", b_rsp, 20);
      chk("rsv_err", 32'(oRSP_ERR), 1);
      chk("rsv_latency", rsp_lat, 1);
      chk("rsv_no_strobes", (wr_cyc - b_wr) + (rd_cyc - b_rdc), 0);

      // Poll that never matches
      slave_val = 32'd0; zero_reads = 1000000; rd_base = rd_cnt;
      b_rsp = rsp_cnt; b_rd = rd_cnt; b_gap = bad_gap;
      send(2'b10, 8'h0A, 32'h0000_0001, 32'h0000_0001);
`ifdef MTL_CFG_POLL_TIMEOUT_EN
      wait_rsp("tmo_rsp_count", b_rsp, 200);
      chk("tmo_reads", rd_cnt - b_rd, 4);
      chk("tmo_err", 32'(oRSP_ERR), 1);
      chk("tmo_data", oRSP_DATA, 0);
      chk("tmo_latency", rsp_lat, 1 + 3 * RD_SPACING + 2);
`else
      n = 0;
      while ((rd_cnt - b_rd) < 100 && n < 100 * RD_SPACING + 100) begin
         @(negedge iCLK);
         n++;
      end
      chk("nto_reached_100_reads", 32'((rd_cnt - b_rd) >= 100), 1);
      chk("nto_no_rsp", rsp_cnt - b_rsp, 0);
      chk("nto_still_busy", 32'(oBUSY), 1);
      @(negedge iCLK); iRST_n = 1'b0;
      @(negedge iCLK); iRST_n = 1'b1;
      @(negedge iCLK);
      chk("nto_ready_after_reset", 32'(oCMD_READY), 1);
`endif
      chk("tmo_spacing", bad_gap - b_gap, 0);

      // Reset in the middle of a stalled write
      exp_addr = 8'h03; exp_wdata = 32'hCAFE_0001;
      iAvalon_waitrequest = 1'b1;
      send(2'b00, 8'h03, 32'hCAFE_0001, 32'd0);
      chk("rstw_write_active", 32'(oAvalon_write), 1);
      b_rsp = rsp_cnt;
      #2 iRST_n = 1'b0;
      #1;
      chk("rstw_write_dropped", 32'(oAvalon_write), 0);
      chk("rstw_ready_in_reset", 32'(oCMD_READY), 1);
      @(negedge iCLK);
      iRST_n = 1'b1;
      iAvalon_waitrequest = 1'b0;
      repeat (4) @(negedge iCLK);
      chk("rstw_no_rsp", rsp_cnt - b_rsp, 0);
      chk("rstw_ready_after", 32'(oCMD_READY), 1);
      chk("never_both_strobes", both_cyc, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
